obj_color_mapper: RTL and testbench

Pipelined, parametrised multi-object colour mapper for the VGA pixel path. It sits between the VGA controller/background generator and the DAC outputs. Per pixel it tests `NUM_OBJ` independently positioned objects, selects the highest-priority hit, and otherwise passes the background colour through. Object attributes are double-buffered and committed only at frame start, and a per-frame overlap (collision) flag is reported.

---
 rtl/obj_color_mapper.sv | 266 ++++++++++++++++++++++++++
 tb/tb_obj_color_mapper.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_color_mapper.sv
// Three-stage multi-object colour mapper for the VGA pixel path; object attributes commit on frame_start.
// Build option OBJ_CIRCLE_EN: circular hit test (per-object multipliers); undefined gives the square test.
module obj_color_mapper #(
    parameter int NUM_OBJ = 4,
    parameter int COORD_W = 10,
    parameter int COLOR_W = 4
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       frame_start,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_OBJ)-1:0] wr_idx,
    input  logic [COORD_W-1:0]         wr_x,
    input  logic [COORD_W-1:0]         wr_y,
    input  logic [COORD_W-1:0]         wr_size,
    input  logic [3*COLOR_W-1:0]       wr_rgb,
    input  logic                       wr_vis,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    input  logic                       blank,
    input  logic [COLOR_W-1:0]         bg_red,
    input  logic [COLOR_W-1:0]         bg_green,
    input  logic [COLOR_W-1:0]         bg_blue,
    output logic [COLOR_W-1:0]         Red,
    output logic [COLOR_W-1:0]         Green,
    output logic [COLOR_W-1:0]         Blue,
    output logic                       blank_out,
    output logic                       hit_valid,
    output logic [$clog2(NUM_OBJ)-1:0] hit_idx,
    output logic                       collision
);
    localparam int IDX_W = $clog2(NUM_OBJ);
    localparam int RGB_W = 3 * COLOR_W;
    localparam int D_W   = COORD_W + 1;
`ifdef OBJ_CIRCLE_EN
    localparam int SQ_W  = 2 * D_W;
    localparam int SUM_W = 2 * COORD_W + 3;
`endif

    // shadow and active attribute banks
    logic [NUM_OBJ-1:0][COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_size_q, sh_size_d;
    logic [NUM_OBJ-1:0][RGB_W-1:0]   sh_rgb_q, sh_rgb_d;
    logic [NUM_OBJ-1:0]              sh_vis_q, sh_vis_d;
    logic [NUM_OBJ-1:0][COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d, act_size_q, act_size_d;
    logic [NUM_OBJ-1:0][RGB_W-1:0]   act_rgb_q, act_rgb_d;
    logic [NUM_OBJ-1:0]              act_vis_q, act_vis_d;

    logic [NUM_OBJ-1:0][D_W-1:0]     s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
    logic [NUM_OBJ-1:0][COORD_W-1:0] s1_size_q, s1_size_d;
    logic [NUM_OBJ-1:0]              s1_vis_q, s1_vis_d;
    logic [NUM_OBJ-1:0][RGB_W-1:0]   s1_rgb_q, s1_rgb_d;
    logic                            s1_blank_q, s1_blank_d;
    logic [RGB_W-1:0]                s1_bg_q, s1_bg_d;

    logic [NUM_OBJ-1:0]              s2_hit_q, s2_hit_d;
    logic [NUM_OBJ-1:0][RGB_W-1:0]   s2_rgb_q, s2_rgb_d;
    logic                            s2_blank_q, s2_blank_d;
    logic [RGB_W-1:0]                s2_bg_q, s2_bg_d;

    logic [RGB_W-1:0]                out_rgb_q, out_rgb_d;
    logic                            blank_out_q, blank_out_d;
    logic                            hit_valid_q, hit_valid_d;
    logic [IDX_W-1:0]                hit_idx_q, hit_idx_d;
    logic                            collision_q, collision_d;
    logic                            sticky_q, sticky_d;

    logic                            win_found;
    logic [IDX_W-1:0]                win_idx;
    logic [RGB_W-1:0]                win_rgb;
    logic                            seen_hit;
    logic                            multi_hit;
    logic                            overlap;

    function automatic logic [D_W-1:0] abs_d(input logic [D_W-1:0] v);
        return v[D_W-1] ? -v : v;
    endfunction

    function automatic logic geom_hit(input logic [D_W-1:0] dx, input logic [D_W-1:0] dy,
                                      input logic [COORD_W-1:0] size);
        logic [D_W-1:0] ax;
        logic [D_W-1:0] ay;
`ifdef OBJ_CIRCLE_EN
        logic [SQ_W-1:0]  sx;
        logic [SQ_W-1:0]  sy;
        logic [SUM_W-1:0] dist2;
        logic [SUM_W-1:0] r2;
`endif
        ax = abs_d(dx);
        ay = abs_d(dy);
`ifdef OBJ_CIRCLE_EN
        sx    = SQ_W'(ax) * SQ_W'(ax);
        sy    = SQ_W'(ay) * SQ_W'(ay);
        dist2 = SUM_W'(sx) + SUM_W'(sy);
        r2    = SUM_W'(size) * SUM_W'(size);
        return dist2 <= r2;
`else
        return (ax <= {1'b0, size}) && (ay <= {1'b0, size});
`endif
    endfunction

    // commit copies the pre-edge shadow, so a same-cycle write waits for the next frame_start
    always_comb begin
        sh_x_d     = sh_x_q;
        sh_y_d     = sh_y_q;
        sh_size_d  = sh_size_q;
        sh_rgb_d   = sh_rgb_q;
        sh_vis_d   = sh_vis_q;
        act_x_d    = act_x_q;
        act_y_d    = act_y_q;
        act_size_d = act_size_q;
        act_rgb_d  = act_rgb_q;
        act_vis_d  = act_vis_q;
        if (frame_start) begin
            act_x_d    = sh_x_q;
            act_y_d    = sh_y_q;
            act_size_d = sh_size_q;
            act_rgb_d  = sh_rgb_q;
            act_vis_d  = sh_vis_q;
        end
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                sh_x_d[i]    = wr_x;
                sh_y_d[i]    = wr_y;
                sh_size_d[i] = wr_size;
                sh_rgb_d[i]  = wr_rgb;
                sh_vis_d[i]  = wr_vis;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            s1_dx_d[i] = {1'b0, DrawX} - {1'b0, act_x_q[i]};
            s1_dy_d[i] = {1'b0, DrawY} - {1'b0, act_y_q[i]};
        end
        s1_size_d  = act_size_q;
        s1_vis_d   = act_vis_q;
        s1_rgb_d   = act_rgb_q;
        s1_blank_d = blank;
        s1_bg_d    = {bg_red, bg_green, bg_blue};
    end

    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            s2_hit_d[i] = s1_vis_q[i] && geom_hit(s1_dx_q[i], s1_dy_q[i], s1_size_q[i]);
        end
        s2_rgb_d   = s1_rgb_q;
        s2_blank_d = s1_blank_q;
        s2_bg_d    = s1_bg_q;
    end

    // lowest index wins; walking downwards leaves the lowest hit last
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_rgb   = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (s2_hit_q[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_rgb   = s2_rgb_q[i];
            end
        end
        seen_hit  = 1'b0;
        multi_hit = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (s2_hit_q[i]) begin
                multi_hit = multi_hit | seen_hit;
                seen_hit  = 1'b1;
            end
        end
        overlap = multi_hit & s2_blank_q;
    end

    always_comb begin
        out_rgb_d   = '0;
        hit_valid_d = 1'b0;
        hit_idx_d   = '0;
        blank_out_d = s2_blank_q;
        if (s2_blank_q) begin
            if (win_found) begin
                out_rgb_d   = win_rgb;
                hit_valid_d = 1'b1;
                hit_idx_d   = win_idx;
            end else begin
                out_rgb_d = s2_bg_q;
            end
        end
        if (frame_start) begin
            collision_d = sticky_q | overlap;
            sticky_d    = 1'b0;
        end else begin
            collision_d = collision_q;
            sticky_d    = sticky_q | overlap;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            sh_size_q   <= '0;
            sh_rgb_q    <= '0;
            sh_vis_q    <= '0;
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_size_q  <= '0;
            act_rgb_q   <= '0;
            act_vis_q   <= '0;
            s1_dx_q     <= '0;
            s1_dy_q     <= '0;
            s1_size_q   <= '0;
            s1_vis_q    <= '0;
            s1_rgb_q    <= '0;
            s1_blank_q  <= 1'b0;
            s1_bg_q     <= '0;
            s2_hit_q    <= '0;
            s2_rgb_q    <= '0;
            s2_blank_q  <= 1'b0;
            s2_bg_q     <= '0;
            out_rgb_q   <= '0;
            blank_out_q <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
            collision_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            sh_size_q   <= sh_size_d;
            sh_rgb_q    <= sh_rgb_d;
            sh_vis_q    <= sh_vis_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            act_size_q  <= act_size_d;
            act_rgb_q   <= act_rgb_d;
            act_vis_q   <= act_vis_d;
            s1_dx_q     <= s1_dx_d;
            s1_dy_q     <= s1_dy_d;
            s1_size_q   <= s1_size_d;
            s1_vis_q    <= s1_vis_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_blank_q  <= s1_blank_d;
            s1_bg_q     <= s1_bg_d;
            s2_hit_q    <= s2_hit_d;
            s2_rgb_q    <= s2_rgb_d;
            s2_blank_q  <= s2_blank_d;
            s2_bg_q     <= s2_bg_d;
            out_rgb_q   <= out_rgb_d;
            blank_out_q <= blank_out_d;
            hit_valid_q <= hit_valid_d;
            hit_idx_q   <= hit_idx_d;
            collision_q <= collision_d;
            sticky_q    <= sticky_d;
        end
    end

    assign Red       = out_rgb_q[RGB_W-1 -: COLOR_W];
    assign Green     = out_rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign Blue      = out_rgb_q[COLOR_W-1:0];
    assign blank_out = blank_out_q;
    assign hit_valid = hit_valid_q;
    assign hit_idx   = hit_idx_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_obj_color_mapper.sv
// Bench for obj_color_mapper: directed scenarios plus random traffic against a pixel-level reference model.
module tb_obj_color_mapper;
    localparam int NUM_OBJ = 4;
    localparam int CW      = 10;
    localparam int COLW    = 4;
    localparam int IW      = $clog2(NUM_OBJ);
    localparam int CMAX    = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            Reset;
    logic            frame_start;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [CW-1:0]   wr_x, wr_y, wr_size;
    logic [3*COLW-1:0] wr_rgb;
    logic            wr_vis;
    logic [CW-1:0]   DrawX, DrawY;
    logic            blank;
    logic [COLW-1:0] bg_red, bg_green, bg_blue;
    logic [COLW-1:0] Red, Green, Blue;
    logic            blank_out, hit_valid, collision;
    logic [IW-1:0]   hit_idx;

    obj_color_mapper #(.NUM_OBJ(NUM_OBJ), .COORD_W(CW), .COLOR_W(COLW)) dut (
        .clk(clk), .Reset(Reset), .frame_start(frame_start),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_size(wr_size),
        .wr_rgb(wr_rgb), .wr_vis(wr_vis),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .Red(Red), .Green(Green), .Blue(Blue), .blank_out(blank_out),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int size; int rgb; bit vis; } obj_t;
    typedef struct { int r; int g; int b; bit bl; bit hv; int idx; bit ov; } res_t;

    obj_t sh[NUM_OBJ];
    obj_t act[NUM_OBJ];
    res_t pipe[$];
    res_t exp_r;
    bit   exp_col;
    bit   sticky;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] actual, input int expected);
        tests++;
        if (actual !== 32'(expected)) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit m_hit(input obj_t o, input int px, input int py);
        int dx;
        int dy;
        dx = px - o.x;
        dy = py - o.y;
        if (!o.vis) return 1'b0;
`ifdef OBJ_CIRCLE_EN
        return (dx * dx + dy * dy) <= (o.size * o.size);
`else
        return ((dx < 0 ? -dx : dx) <= o.size) && ((dy < 0 ? -dy : dy) <= o.size);
`endif
    endfunction

    task automatic model_clear();
        for (int j = 0; j < NUM_OBJ; j++) begin
            sh[j]  = '{default: 0};
            act[j] = '{default: 0};
        end
        pipe.delete();
        exp_r   = '{default: 0};
        sticky  = 1'b0;
        exp_col = 1'b0;
    endtask

    // one clock edge of the reference: classify the current pixel, age the 3-deep pipe, commit, write
    task automatic model_edge();
        res_t r;
        int   cnt;
        int   best;
        bit   ov;
        if (Reset) begin
            model_clear();
            return;
        end
        cnt  = 0;
        best = -1;
        for (int j = 0; j < NUM_OBJ; j++) begin
            if (m_hit(act[j], int'(DrawX), int'(DrawY))) begin
                cnt++;
                if (best < 0) best = j;
            end
        end
        r = '{default: 0};
        r.bl = blank;
        if (blank) begin
            if (best >= 0) begin
                r.r   = (act[best].rgb >> 8) & 15;
                r.g   = (act[best].rgb >> 4) & 15;
                r.b   = act[best].rgb & 15;
                r.hv  = 1'b1;
                r.idx = best;
            end else begin
                r.r = int'(bg_red);
                r.g = int'(bg_green);
                r.b = int'(bg_blue);
            end
        end
        r.ov = blank && (cnt >= 2);
        pipe.push_back(r);
        if (pipe.size() > 3) void'(pipe.pop_front());
        if (pipe.size() == 3) exp_r = pipe[0];
        else exp_r = '{default: 0};
        ov = exp_r.ov;
        if (frame_start) begin
            exp_col = sticky | ov;
            sticky  = 1'b0;
            for (int j = 0; j < NUM_OBJ; j++) act[j] = sh[j];
        end else begin
            sticky = sticky | ov;
        end
        if (wr_en && int'(wr_idx) < NUM_OBJ)
            sh[wr_idx] = '{int'(wr_x), int'(wr_y), int'(wr_size), int'(wr_rgb), wr_vis};
    endtask

    task automatic compare_outputs();
        check("red", Red, exp_r.r);
        check("green", Green, exp_r.g);
        check("blue", Blue, exp_r.b);
        check("blank_out", blank_out, int'(exp_r.bl));
        check("hit_valid", hit_valid, int'(exp_r.hv));
        check("hit_idx", hit_idx, exp_r.idx);
        check("collision", collision, int'(exp_col));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic pix(input int x, input int y, input bit bl, input int n);
        DrawX = CW'(x);
        DrawY = CW'(y);
        blank = bl;
        repeat (n) step();
    endtask

    task automatic write_obj(input int idx, input int x, input int y, input int s, input int rgb,
                             input bit vis, input bit with_fs);
        wr_en       = 1'b1;
        wr_idx      = IW'(idx);
        wr_x        = CW'(x);
        wr_y        = CW'(y);
        wr_size     = CW'(s);
        wr_rgb      = 12'(rgb);
        wr_vis      = vis;
        frame_start = with_fs;
        step();
        wr_en       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    function automatic int rand_coord();
        case ($urandom_range(0, 3))
            0: return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : int'($urandom_range(1017, 1023));
            3: return int'($urandom_range(0, CMAX));
            default: return int'($urandom_range(180, 260));
        endcase
    endfunction

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > CMAX) ? CMAX : v);
    endfunction

    initial begin
        int j;
        int s;
        Reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0;
        wr_x = '0; wr_y = '0; wr_size = '0; wr_rgb = '0; wr_vis = 1'b0;
        DrawX = '0; DrawY = '0; blank = 1'b0;
        bg_red = '0; bg_green = '0; bg_blue = '0;
        model_clear();
        step();
        step();
        check("rst_red", Red, 0);
        check("rst_hit_valid", hit_valid, 0);
        check("rst_collision", collision, 0);
        Reset = 1'b0;

        bg_red = 4'h5; bg_green = 4'hA; bg_blue = 4'h3;
        pix(0, 0, 1'b1, 3);
        check("bg_red", Red, 5);
        check("bg_green", Green, 10);
        check("bg_blue", Blue, 3);
        check("bg_hit_valid", hit_valid, 0);

        write_obj(1, 100, 100, 10, 12'hF00, 1'b1, 1'b0);
        pix(100, 100, 1'b1, 3);
        check("uncommitted_hit", hit_valid, 0);
        pulse_fs();
        pix(100, 100, 1'b1, 3);
        check("obj1_red", Red, 15);
        check("obj1_green", Green, 0);
        check("obj1_blue", Blue, 0);
        check("obj1_idx", hit_idx, 1);
        check("obj1_valid", hit_valid, 1);

        pix(107, 107, 1'b1, 3);
        check("edge_107", hit_valid, 1);
        pix(108, 108, 1'b1, 3);
`ifdef OBJ_CIRCLE_EN
        check("corner_108_circle", hit_valid, 0);
        check("corner_108_red", Red, 5);
`else
        check("corner_108_square", hit_valid, 1);
        check("corner_108_red", Red, 15);
`endif
        pix(111, 100, 1'b1, 3);
        check("outside_111", hit_valid, 0);

        write_obj(0, 100, 100, 5, 12'h0F0, 1'b1, 1'b0);
        pulse_fs();
        pix(100, 100, 1'b1, 3);
        check("prio_green", Green, 15);
        check("prio_red", Red, 0);
        check("prio_idx", hit_idx, 0);
        pix(500, 500, 1'b1, 3);
        pulse_fs();
        check("collision_set", collision, 1);
        pix(500, 500, 1'b1, 3);
        pulse_fs();
        check("collision_clear", collision, 0);

        write_obj(0, 2, 2, 4, 12'h00F, 1'b1, 1'b0);
        write_obj(1, 100, 100, 10, 12'hF00, 1'b0, 1'b0);
        pulse_fs();
        pix(1022, 1022, 1'b1, 3);
        check("nowrap_1022", hit_valid, 0);
        pix(1020, 1020, 1'b1, 3);
        check("nowrap_1020", hit_valid, 0);
        pix(0, 0, 1'b1, 3);
        check("near0_hit", hit_valid, 1);
        check("near0_blue", Blue, 15);
        pix(0, 0, 1'b0, 3);
        check("blanked_blue", Blue, 0);
        check("blanked_hit", hit_valid, 0);
        check("blanked_bo", blank_out, 0);

        write_obj(3, 300, 300, 8, 12'hABC, 1'b1, 1'b1);
        pix(300, 300, 1'b1, 3);
        check("samecycle_hidden", hit_valid, 0);
        pulse_fs();
        pix(300, 300, 1'b1, 3);
        check("samecycle_shown", hit_valid, 1);
        check("samecycle_idx", hit_idx, 3);
        check("samecycle_red", Red, 10);

        for (int c = 0; c < 4000; c++) begin
            wr_en = ($urandom_range(0, 7) == 0);
            if (wr_en) begin
                wr_idx  = IW'($urandom_range(0, NUM_OBJ - 1));
                wr_x    = CW'(rand_coord());
                wr_y    = CW'(rand_coord());
                wr_size = CW'($urandom_range(0, 60));
                wr_rgb  = 12'($urandom_range(0, 4095));
                wr_vis  = ($urandom_range(0, 3) != 0);
            end
            frame_start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) begin
                j = int'($urandom_range(0, NUM_OBJ - 1));
                s = act[j].size;
                DrawX = CW'(clampc(act[j].x - s - 2 + int'($urandom_range(0, 2 * s + 4))));
                DrawY = CW'(clampc(act[j].y - s - 2 + int'($urandom_range(0, 2 * s + 4))));
            end else begin
                DrawX = CW'(rand_coord());
                DrawY = CW'(rand_coord());
            end
            blank    = ($urandom_range(0, 7) != 0);
            bg_red   = COLW'($urandom_range(0, 15));
            bg_green = COLW'($urandom_range(0, 15));
            bg_blue  = COLW'($urandom_range(0, 15));
            step();
        end
        wr_en = 1'b0;
        frame_start = 1'b0;

        bg_red = 4'h5; bg_green = 4'hA; bg_blue = 4'h3;
        write_obj(2, 600, 600, 20, 12'h123, 1'b1, 1'b0);
        pulse_fs();
        pix(600, 600, 1'b1, 4);
        check("pre_reset_hit", hit_valid, 1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_red", Red, 0);
        check("async_green", Green, 0);
        check("async_blue", Blue, 0);
        check("async_bo", blank_out, 0);
        check("async_hv", hit_valid, 0);
        check("async_idx", hit_idx, 0);
        check("async_col", collision, 0);
        step();
        step();
        Reset = 1'b0;
        pix(600, 600, 1'b1, 3);
        check("post_reset_hit", hit_valid, 0);
        check("post_reset_red", Red, 5);
        pulse_fs();
        pix(600, 600, 1'b1, 3);
        check("post_reset_commit", hit_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
